// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - shared types and width helpers for the accu scheduler
package accu_pkg;

  localparam int unsigned ACCU_GROUP_LEN = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  function automatic int unsigned sum_width(input int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/accu_id_fifo.sv
// rtl/accu_id_fifo.sv - in-flight requester id FIFO (DEPTH must be a power of two >= 2)
module accu_id_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         nempty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign nempty_o = (cnt_q != '0);
  assign data_o   = mem_q[rd_q];
  assign do_pop   = pop_i & nempty_o;
  assign do_push  = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only consumed while nempty_o is high.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/accu_rr_sched.sv
// rtl/accu_rr_sched.sv - round-robin group scheduler in front of one shared accu
module accu_rr_sched
  import accu_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GROUP_LEN = ACCU_GROUP_LEN,
  parameter int unsigned ID_DEPTH  = 2,
  parameter int unsigned SUM_W     = sum_width(DATA_W),
  parameter int unsigned ID_W      = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      acc_valid_a,
  input  logic                      acc_ready_a,
  output logic [DATA_W-1:0]         acc_data_in,
  input  logic                      acc_valid_b,
  output logic                      acc_ready_b,
  input  logic [SUM_W-1:0]          acc_data_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SUM_W-1:0]          res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy,
  output logic                      err_orphan
);

  localparam int unsigned CNT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GROUP_LEN - 1);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_nempty;
  logic [ID_W-1:0]  fifo_head;
  logic             beat_hs;

  // Scan from last+NUM_REQ down to last+1 so the nearest valid requester after last wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = (int'(last) + k) % int'(NUM_REQ);
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign beat_hs = req_valid[grant_q] & acc_ready_a;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    fifo_push   = 1'b0;
    req_ready   = '0;
    acc_valid_a = 1'b0;
    acc_data_in = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid && !fifo_full) begin
          grant_d = rr_pick(req_valid, last_q);
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        acc_valid_a        = req_valid[grant_q];
        acc_data_in        = req_data[int'(grant_q) * int'(DATA_W) +: DATA_W];
        req_ready[grant_q] = acc_ready_a;
        if (beat_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            fifo_push = 1'b1;
            last_d    = grant_q;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Results are only accepted while an owner id is queued; otherwise flag it.
  assign err_d       = err_q | (acc_valid_b & ~fifo_nempty);
  assign res_valid   = acc_valid_b & fifo_nempty;
  assign acc_ready_b = res_ready & fifo_nempty;
  assign fifo_pop    = acc_valid_b & acc_ready_b;
  assign res_data    = res_valid ? acc_data_out : '0;
  assign res_id      = fifo_nempty ? fifo_head : '0;
  assign busy        = (state_q == BURST);
  assign err_orphan  = err_q;

  accu_id_fifo #(
    .W     (ID_W),
    .DEPTH (ID_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (fifo_push),
    .data_i   (grant_q),
    .pop_i    (fifo_pop),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .nempty_o (fifo_nempty)
  );

endmodule

// File: tb/tb_accu_rr_sched.sv
// tb/tb_accu_rr_sched.sv - randomized self-checking bench for accu_rr_sched
module tb_accu_rr_sched;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int GL    = 4;
  localparam int DEPTH = 2;
  localparam int SW    = 10;
  localparam int IW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             acc_valid_a, acc_ready_a;
  logic [DW-1:0]    acc_data_in;
  logic             acc_valid_b, acc_ready_b;
  logic [SW-1:0]    acc_data_out;
  logic             res_valid, res_ready;
  logic [SW-1:0]    res_data;
  logic [IW-1:0]    res_id;
  logic             busy, err_orphan;

  always #5 clk = ~clk;

  accu_rr_sched #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .GROUP_LEN (GL),
    .ID_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .acc_valid_a  (acc_valid_a),
    .acc_ready_a  (acc_ready_a),
    .acc_data_in  (acc_data_in),
    .acc_valid_b  (acc_valid_b),
    .acc_ready_b  (acc_ready_b),
    .acc_data_out (acc_data_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_id       (res_id),
    .busy         (busy),
    .err_orphan   (err_orphan)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // environment: per-requester beat queues and a behavioural accumulator
  logic [DW-1:0] src_q [NR][$];
  logic [NR-1:0] en;
  int            ra_pct, rr_pct;
  bit            force_b;
  int            stub_sum, stub_cnt;
  logic [SW-1:0] stub_q [$];

  // reference model of the scheduler's observable behaviour
  int m_owner, m_last, m_cnt, m_sum;
  bit m_err;
  int m_idq [$];
  int m_sumq [$];

  int grp_log [$];
  int res_log [$];
  int sum_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int rr_next(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic bit idle_all();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
    return (m_owner < 0) && (m_idq.size() == 0) && (stub_q.size() == 0);
  endfunction

  task automatic drive();
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      if (req_valid[i]) req_data[i*DW +: DW] = src_q[i][0];
    end
    acc_valid_b  = force_b || (stub_q.size() > 0);
    acc_data_out = (stub_q.size() > 0) ? stub_q[0] : '0;
    acc_ready_a  = ($urandom_range(99) < ra_pct);
    res_ready    = ($urandom_range(99) < rr_pct);
  endtask

  task automatic step();
    logic [NR-1:0] s_rv, s_rr, exp_rdy;
    logic          s_ahs, s_bhs;
    logic [DW-1:0] s_din;
    int            sz;
    @(negedge clk);
    s_rv  = req_valid;
    s_rr  = req_ready;
    s_ahs = acc_valid_a && acc_ready_a;
    s_bhs = acc_valid_b && acc_ready_b;
    s_din = acc_data_in;
    sz    = m_idq.size();

    chk("err_orphan", 32'(err_orphan), 32'(m_err));
    if (m_owner < 0) begin
      chk("busy_idle", 32'(busy), 0);
      chk("req_ready_idle", 32'(req_ready), 0);
      chk("acc_valid_a_idle", 32'(acc_valid_a), 0);
      chk("acc_data_in_idle", 32'(acc_data_in), 0);
    end else begin
      exp_rdy = '0;
      exp_rdy[m_owner] = acc_ready_a;
      chk("busy_burst", 32'(busy), 1);
      chk("req_ready_burst", 32'(req_ready), 32'(exp_rdy));
      chk("acc_valid_a_burst", 32'(acc_valid_a), 32'(req_valid[m_owner]));
      if (req_valid[m_owner]) chk("acc_data_in", 32'(acc_data_in), 32'(src_q[m_owner][0]));
    end
    chk("res_valid", 32'(res_valid), 32'(acc_valid_b && sz > 0));
    chk("acc_ready_b", 32'(acc_ready_b), 32'(res_ready && sz > 0));
    if (acc_valid_b && sz > 0) begin
      chk("res_id", 32'(res_id), 32'(m_idq[0]));
      chk("res_data_fwd", 32'(res_data), 32'(acc_data_out));
    end

    if (s_ahs && m_owner >= 0 && m_cnt == 0)
      for (int j = 0; j < NR; j++) if (s_rr[j]) grp_log.push_back(j);

    if (acc_valid_b && sz == 0) m_err = 1'b1;
    if (acc_valid_b && res_ready && sz > 0) begin
      res_log.push_back(int'(res_id));
      sum_log.push_back(int'(res_data));
      chk("res_sum", 32'(res_data), 32'(m_sumq[0]));
      void'(m_idq.pop_front());
      void'(m_sumq.pop_front());
    end
    if (m_owner < 0) begin
      if (|req_valid && sz < DEPTH) begin
        m_owner = rr_next(req_valid, m_last);
        m_cnt   = 0;
        m_sum   = 0;
      end
    end else if (req_valid[m_owner] && acc_ready_a) begin
      m_sum += int'(src_q[m_owner][0]);
      m_cnt++;
      if (m_cnt == GL) begin
        m_idq.push_back(m_owner);
        m_sumq.push_back(m_sum);
        m_last  = m_owner;
        m_owner = -1;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (s_rv[i] && s_rr[i]) void'(src_q[i].pop_front());
    if (s_ahs) begin
      stub_sum += int'(s_din);
      stub_cnt++;
      if (stub_cnt == GL) begin
        stub_q.push_back(SW'(stub_sum));
        stub_sum = 0;
        stub_cnt = 0;
      end
    end
    if (s_bhs && stub_q.size() > 0) void'(stub_q.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    stub_q.delete();
    m_idq.delete();
    m_sumq.delete();
    grp_log.delete();
    res_log.delete();
    sum_log.delete();
    stub_sum = 0;
    stub_cnt = 0;
    force_b  = 1'b0;
    en       = '1;
    ra_pct   = 100;
    rr_pct   = 100;
    m_owner  = -1;
    m_last   = NR - 1;
    m_cnt    = 0;
    m_sum    = 0;
    m_err    = 1'b0;
    drive();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_acc_valid_a", 32'(acc_valid_a), 0);
    chk("rst_acc_data_in", 32'(acc_data_in), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_acc_ready_b", 32'(acc_ready_b), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_err_orphan", 32'(err_orphan), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!idle_all() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(idle_all()), 1);
  endtask

  task automatic wait_src(input int idx, input int left, input int budget);
    int n = 0;
    while (src_q[idx].size() > left && n < budget) begin
      step();
      n++;
    end
    chk("wait_src_done", 32'(src_q[idx].size() > left), 0);
  endtask

  function automatic int at(input int q [$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // single requester, no contention
    do_reset();
    src_q[2] = '{8'd10, 8'd20, 8'd30, 8'd40};
    drive();
    #2;
    chk("s1_bubble_valid_a", 32'(acc_valid_a), 0);
    chk("s1_bubble_ready", 32'(req_ready), 0);
    drain("s1", 50);
    chk("s1_nres", 32'(res_log.size()), 1);
    chk("s1_id", 32'(at(res_log, 0)), 2);
    chk("s1_sum", 32'(at(sum_log, 0)), 100);

    // all requesters valid from reset
    do_reset();
    for (int i = 0; i < NR; i++)
      repeat (2 * GL) src_q[i].push_back(8'($urandom));
    drive();
    drain("s2", 200);
    for (int k = 0; k < 5; k++)
      chk($sformatf("s2_order%0d", k), 32'(at(grp_log, k)), 32'(exp_order[k]));

    // granted requester stalls mid-group while another waits
    do_reset();
    repeat (GL) src_q[1].push_back(8'($urandom));
    repeat (GL) src_q[3].push_back(8'($urandom));
    drive();
    wait_src(1, 2, 20);
    en[1] = 1'b0;
    drive();
    repeat (5) step();
    #1;
    chk("s3_busy_hold", 32'(busy), 1);
    chk("s3_rdy3_blocked", 32'(req_ready[3]), 0);
    en[1] = 1'b1;
    drive();
    drain("s3", 60);
    chk("s3_grp0", 32'(at(grp_log, 0)), 1);
    chk("s3_grp1", 32'(at(grp_log, 1)), 3);

    // result backpressure fills the id FIFO
    do_reset();
    rr_pct = 0;
    for (int i = 0; i < 3; i++) repeat (GL) src_q[i].push_back(8'($urandom));
    drive();
    repeat (30) step();
    #1;
    chk("s4_busy_full", 32'(busy), 0);
    chk("s4_ready_full", 32'(req_ready), 0);
    chk("s4_res_valid", 32'(res_valid), 1);
    rr_pct = 100;
    drive();
    drain("s4", 80);
    for (int k = 0; k < 3; k++)
      chk($sformatf("s4_res_id%0d", k), 32'(at(res_log, k)), 32'(k));

    // orphan result
    do_reset();
    force_b = 1'b1;
    drive();
    #1;
    chk("s5_acc_ready_b", 32'(acc_ready_b), 0);
    step();
    step();
    force_b = 1'b0;
    drive();
    repeat (3) step();
    #1;
    chk("s5_err_sticky", 32'(err_orphan), 1);

    // reset in the middle of a group
    do_reset();
    src_q[0] = '{8'd200, 8'd201, 8'd202, 8'd203};
    drive();
    wait_src(0, 2, 20);
    do_reset();
    src_q[0] = '{8'd5, 8'd6, 8'd7, 8'd8};
    drive();
    drain("s6", 40);
    chk("s6_nres", 32'(res_log.size()), 1);
    chk("s6_id", 32'(at(res_log, 0)), 0);
    chk("s6_sum", 32'(at(sum_log, 0)), 26);

    // randomized traffic
    do_reset();
    ra_pct = 70;
    rr_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) begin
        int r;
        r = int'($urandom_range(NR - 1));
        if (src_q[r].size() < 8) repeat (GL) src_q[r].push_back(8'($urandom));
      end
      if ($urandom_range(15) == 0) en = NR'($urandom);
      drive();
      step();
    end
    en     = '1;
    ra_pct = 100;
    rr_pct = 100;
    drive();
    drain("s7", 2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
